// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I writeback types and load funct3 encodings
package rv_pkg;

   localparam int DATA_W = 32;
   localparam int RIDX_W = 5;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [1:0]        src;
      logic [2:0]        funct3;
      logic [RIDX_W-1:0] rd;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [DATA_W-1:0] pc4;
   } wb_regs_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational byte/halfword extraction and extension of a loaded word
module load_extend
   import rv_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] ext_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word_i[7:0];
      case (offset_i)
         2'd1:    byte_v = word_i[15:8];
         2'd2:    byte_v = word_i[23:16];
         2'd3:    byte_v = word_i[31:24];
         default: byte_v = word_i[7:0];
      endcase
      // misaligned halfwords silently use the halfword selected by offset bit 1
      half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];

      ext_o = word_i;
      case (funct3_i)
         F3_LB:   ext_o = {{24{byte_v[7]}}, byte_v};
         F3_LBU:  ext_o = {24'd0, byte_v};
         F3_LH:   ext_o = {{16{half_v[15]}}, half_v};
         F3_LHU:  ext_o = {16'd0, half_v};
         default: ext_o = word_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - M/W pipeline register and writeback result select; WB_INSTRET_EN adds a retire counter
module wb_stage
   import rv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  ValidM_i,
   input  logic                  RegWriteM_i,
   input  logic [1:0]            ResultSrcM_i,
   input  logic [2:0]            Funct3M_i,
   input  logic [REG_ADDR_W-1:0] RdM_i,
   input  logic [XLEN-1:0]       ALUResultM_i,
   input  logic [XLEN-1:0]       ReadDataM_i,
   input  logic [XLEN-1:0]       PCPlus4M_i,
`ifdef WB_INSTRET_EN
   output logic [63:0]           instret_o,
`endif
   output logic                  ValidW_o,
   output logic                  RegWriteW_o,
   output logic [REG_ADDR_W-1:0] RdW_o,
   output logic [XLEN-1:0]       ResultW_o
);

   wb_regs_t    w_q, w_d;
   logic [31:0] load_val;
   logic [31:0] result;

   always_comb begin
      w_d = w_q;
      if (flush_i) begin
         w_d = '0;
      end else if (!stall_i) begin
         w_d.valid    = ValidM_i;
         w_d.regwrite = RegWriteM_i;
         w_d.src      = ResultSrcM_i;
         w_d.funct3   = Funct3M_i;
         w_d.rd       = RdM_i;
         w_d.alu      = ALUResultM_i;
         w_d.rdata    = ReadDataM_i;
         w_d.pc4      = PCPlus4M_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) w_q <= '0;
      else     w_q <= w_d;
   end

   load_extend u_load_extend (
      .word_i   (w_q.rdata),
      .offset_i (w_q.alu[1:0]),
      .funct3_i (w_q.funct3),
      .ext_o    (load_val)
   );

   // src 11 falls through to the ALU result
   always_comb begin
      result = w_q.alu;
      case (w_q.src)
         RES_MEM: result = load_val;
         RES_PC4: result = w_q.pc4;
         default: result = w_q.alu;
      endcase
      if (!w_q.valid) result = '0;
   end

   assign ValidW_o    = w_q.valid;
   assign RegWriteW_o = w_q.valid & w_q.regwrite & (w_q.rd != '0);
   assign RdW_o       = w_q.rd;
   assign ResultW_o   = result;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;

   // a flushed-but-unstalled W slot still retires its instruction
   always_ff @(posedge clk) begin
      if (rst)                       instret_q <= '0;
      else if (w_q.valid && !stall_i) instret_q <= instret_q + 64'd1;
   end

   assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized and directed self-checking bench for wb_stage (WB_INSTRET_EN optional)
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, ValidM_i, RegWriteM_i;
   logic [1:0]  ResultSrcM_i;
   logic [2:0]  Funct3M_i;
   logic [4:0]  RdM_i;
   logic [31:0] ALUResultM_i, ReadDataM_i, PCPlus4M_i;
   logic        ValidW_o, RegWriteW_o;
   logic [4:0]  RdW_o;
   logic [31:0] ResultW_o;
`ifdef WB_INSTRET_EN
   logic [63:0] instret_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .ValidM_i     (ValidM_i),
      .RegWriteM_i  (RegWriteM_i),
      .ResultSrcM_i (ResultSrcM_i),
      .Funct3M_i    (Funct3M_i),
      .RdM_i        (RdM_i),
      .ALUResultM_i (ALUResultM_i),
      .ReadDataM_i  (ReadDataM_i),
      .PCPlus4M_i   (PCPlus4M_i),
`ifdef WB_INSTRET_EN
      .instret_o    (instret_o),
`endif
      .ValidW_o     (ValidW_o),
      .RegWriteW_o  (RegWriteW_o),
      .RdW_o        (RdW_o),
      .ResultW_o    (ResultW_o)
   );

   always #5 clk = ~clk;

   // reference: the instruction currently sitting in W, as plain fields
   bit          m_valid, m_rw;
   bit [1:0]    m_src;
   bit [2:0]    m_f3;
   bit [4:0]    m_rd;
   bit [31:0]   m_alu, m_word, m_pc4;
   longint unsigned m_instret;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] ref_load(bit [31:0] w, bit [1:0] off, bit [2:0] f3);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 256 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h - 65536 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic bit [31:0] ref_result();
      if (!m_valid) return 0;
      if (m_src == 2'b01) return ref_load(m_word, m_alu[1:0], m_f3);
      if (m_src == 2'b10) return m_pc4;
      return m_alu;
   endfunction

   task automatic set_m(bit v, bit rw, bit [1:0] src, bit [2:0] f3, bit [4:0] rd,
                        bit [31:0] alu, bit [31:0] word, bit [31:0] pc4);
      ValidM_i = v; RegWriteM_i = rw; ResultSrcM_i = src; Funct3M_i = f3;
      RdM_i = rd; ALUResultM_i = alu; ReadDataM_i = word; PCPlus4M_i = pc4;
   endtask

   // one clock: model follows rst > flush > stall > capture, then outputs are compared
   task automatic cycle(input string tag);
      @(posedge clk);
      if (rst) begin
         {m_valid, m_rw, m_src, m_f3, m_rd, m_alu, m_word, m_pc4} = '0;
         m_instret = 0;
      end else begin
         if (m_valid && !stall_i) m_instret = m_instret + 1;
         if (flush_i) begin
            {m_valid, m_rw, m_src, m_f3, m_rd, m_alu, m_word, m_pc4} = '0;
         end else if (!stall_i) begin
            m_valid = ValidM_i; m_rw = RegWriteM_i; m_src = ResultSrcM_i; m_f3 = Funct3M_i;
            m_rd = RdM_i; m_alu = ALUResultM_i; m_word = ReadDataM_i; m_pc4 = PCPlus4M_i;
         end
      end
      #1;
      check({tag, ".valid"}, ValidW_o, m_valid);
      check({tag, ".regwrite"}, RegWriteW_o, m_valid && m_rw && (m_rd != 0));
      check({tag, ".rd"}, RdW_o, m_rd);
      check({tag, ".result"}, ResultW_o, ref_result());
`ifdef WB_INSTRET_EN
      check({tag, ".instret"}, instret_o, m_instret);
`endif
   endtask

   task automatic load_case(input string tag, bit [2:0] f3, bit [31:0] alu, bit [31:0] word,
                            bit [31:0] exp);
      set_m(1, 1, 2'b01, f3, 5'd5, alu, word, 32'h0);
      cycle(tag);
      check({tag, ".const"}, ResultW_o, exp);
   endtask

   initial begin
      rst = 1; stall_i = 0; flush_i = 0;
      set_m(0, 0, 0, 0, 0, 0, 0, 0);
      cycle("reset");
      check("reset.result0", ResultW_o, 0);
      rst = 0;

      load_case("lb_off1", 3'b000, 32'h1001, 32'h80FF7F01, 32'h0000007F);
      check("lb_off1.rw", RegWriteW_o, 1);
      check("lb_off1.rd5", RdW_o, 5);
      load_case("lb_off3",  3'b000, 32'h1003, 32'h80FF7F01, 32'hFFFFFF80);
      load_case("lbu_off3", 3'b100, 32'h1003, 32'h80FF7F01, 32'h00000080);
      load_case("lh_off2",  3'b001, 32'h2002, 32'h80011234, 32'hFFFF8001);
      load_case("lhu_off2", 3'b101, 32'h2002, 32'h80011234, 32'h00008001);
      load_case("lh_off0",  3'b001, 32'h2000, 32'h80011234, 32'h00001234);
      load_case("lh_off3",  3'b001, 32'h2003, 32'h80011234, 32'hFFFF8001);
      load_case("lw",       3'b010, 32'h2003, 32'h80011234, 32'h80011234);
      load_case("f3_011",   3'b011, 32'h2001, 32'h80011234, 32'h80011234);

      set_m(1, 1, 2'b00, 0, 5'd0, 32'hDEADBEEF, 0, 0);
      cycle("x0");
      check("x0.rw", RegWriteW_o, 0);
      check("x0.result", ResultW_o, 32'hDEADBEEF);

      set_m(1, 1, 2'b11, 0, 5'd7, 32'h12345678, 0, 32'h55);
      cycle("src11");
      check("src11.const", ResultW_o, 32'h12345678);

      set_m(1, 1, 2'b10, 0, 5'd9, 32'h40, 0, 32'h104);
      cycle("pc4");
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         set_m($urandom_range(0, 1), 1, $urandom_range(0, 3), 3'($urandom), 5'($urandom),
               $urandom, $urandom, $urandom);
         cycle("stall");
         check("stall.hold", ResultW_o, 32'h104);
      end
      flush_i = 1;
      cycle("flush_stall");
      check("flush.valid0", ValidW_o, 0);
      check("flush.result0", ResultW_o, 0);
      flush_i = 0; stall_i = 0;

      set_m(1, 1, 2'b00, 0, 5'd3, 32'hCAFE0000, 0, 0);
      cycle("pre_rst");
      stall_i = 1; rst = 1;
      cycle("mid_rst");
      check("rst.valid0", ValidW_o, 0);
      check("rst.rd0", RdW_o, 0);
      rst = 0; stall_i = 0;
      set_m(1, 1, 2'b10, 0, 5'd4, 0, 0, 32'h200);
      cycle("post_rst");
      check("post_rst.const", ResultW_o, 32'h200);

      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 99) < 2);
         stall_i = ($urandom_range(0, 99) < 15);
         flush_i = ($urandom_range(0, 99) < 6);
         set_m($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom);
         cycle("rand");
      end
      rst = 0; stall_i = 0; flush_i = 0;

`ifdef WB_INSTRET_EN
      rst = 1;
      cycle("ir_rst");
      rst = 0;
      begin
         int issued = 0;
         int step = 0;
         while (issued < 10) begin
            stall_i = (step == 3 || step == 7);
            if (step == 5) begin
               set_m(0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
               set_m(1, 1, 0, 0, 5'd1, $urandom, 0, 0);
               if (!stall_i) issued++;
            end
            cycle("ir_seq");
            step++;
         end
         stall_i = 0;
         set_m(0, 0, 0, 0, 0, 0, 0, 0);
         cycle("ir_drain");
         cycle("ir_drain");
         check("instret.ten", instret_o, 64'd10);
      end
      set_m(1, 1, 0, 0, 5'd2, 32'h1, 0, 0);
      cycle("ir_pre_wrap");
      @(negedge clk);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      set_m(0, 0, 0, 0, 0, 0, 0, 0);
      cycle("ir_wrap");
      check("instret.wrap", instret_o, 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
